pcpu_mem_host: RTL

Memory-side host for the 16-bit pipeline processor (`pcpu`). It holds the 256x16 instruction memory and the 256x16 data memory, and answers the processor's `i_addr` and `d_addr`/`d_we` requests. It sequences the processor's `enable` and `start` inputs and detects program completion. An external loader (a bench or a UART front-end) fills memory before a run and reads it back afterwards.

---
 rtl/pcpu_mem_host.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pcpu_mem_host.sv
// Memory-side host for pcpu: 256x16 instruction and data memories, a run sequencer and a loader/readback port.
// Processor reads are combinational, rd_data has one cycle of latency, and loads are only accepted in IDLE or DONE.
module pcpu_mem_host #(
    parameter int         AW      = 8,
    parameter int         DW      = 16,
    parameter logic [4:0] HALT_OP = 5'b00001,
    parameter int         DRAIN   = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic          ld_sel,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          go,
    input  logic          rd_sel,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_datain,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_dataout,
    input  logic          d_we,
    output logic [DW-1:0] d_datain,
    output logic          enable,
    output logic          start,
    output logic          busy,
    output logic          done,
    output logic [7:0]    store_count
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(DRAIN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    store_count_q, store_count_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic [DW-1:0] imem_q [DEPTH];
    logic [DW-1:0] dmem_q [DEPTH];

    logic          ld_fire;
    logic          st_fire;
    logic          go_fire;
    logic          halt_seen;
    logic          imem_we;
    logic          dmem_we;
    logic [AW-1:0] dmem_waddr;
    logic [DW-1:0] dmem_wdata;

    assign i_datain = imem_q[i_addr];
    assign d_datain = dmem_q[d_addr];

    always_comb begin
        ld_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
        enable    = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_DRAIN);
        busy      = enable;
        start     = (state_q == S_START);
        done      = (state_q == S_DONE);
        halt_seen = (i_datain[DW-1:DW-5] == HALT_OP);
        ld_fire   = ld_valid && ld_ready;
        go_fire   = go && ld_ready;
        st_fire   = d_we && ((state_q == S_RUN) || (state_q == S_DRAIN));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (halt_seen) begin
                    state_d = S_DRAIN;
                    cnt_d   = CW'(DRAIN - 1);
                end
            end
            // HALT is not re-examined here, so refetching it cannot extend the drain.
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_DONE:  if (go) state_d = S_START;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        store_count_d = store_count_q;
        if (go_fire) begin
            store_count_d = '0;
        end else if (st_fire && (store_count_q != 8'hFF)) begin
            store_count_d = store_count_q + 8'd1;
        end
    end

    always_comb begin
        rd_data_d  = rd_sel ? dmem_q[rd_addr] : imem_q[rd_addr];
        imem_we    = ld_fire && !ld_sel;
        dmem_we    = (ld_fire && ld_sel) || st_fire;
        dmem_waddr = st_fire ? d_addr : ld_addr;
        dmem_wdata = st_fire ? d_dataout : ld_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            store_count_q <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            store_count_q <= store_count_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Memory contents survive reset; only writes are suppressed while it is held.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (imem_we) imem_q[ld_addr]    <= ld_data;
            if (dmem_we) dmem_q[dmem_waddr] <= dmem_wdata;
        end
    end

    assign rd_data     = rd_data_q;
    assign store_count = store_count_q;

endmodule
